// File: rtl/count_checker.sv
// rtl/count_checker.sv - checks that a free-running count advances by +1 mod 2^W; reports lock, errors and wraps.
// Optional feature macro: COUNT_CHECKER_STICKY_EN (a locked mismatch latches FAULT until clr).
module count_checker #(
  parameter int W        = 3,
  parameter int LOCK_LEN = 4,
  parameter int ERR_W    = 8,
  parameter int WRAP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      cnt_in,
  input  logic              cnt_vld,
  input  logic              clr,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam int GW = $clog2(LOCK_LEN + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
`ifdef COUNT_CHECKER_STICKY_EN
    FAULT  = 2'd3,
`endif
    LOCKED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        exp_q, exp_d;
  logic [GW-1:0]       good_q, good_d;
  logic                locked_q, locked_d;
  logic                err_pulse_q, err_pulse_d;
  logic                wrap_pulse_q, wrap_pulse_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;
  logic                match;

  assign match = (cnt_in == exp_q);

  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    good_d       = good_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;
    err_cnt_d    = err_cnt_q;
    wrap_cnt_d   = wrap_cnt_q;
    if (clr) begin
      state_d    = IDLE;
      exp_d      = '0;
      good_d     = '0;
      err_cnt_d  = '0;
      wrap_cnt_d = '0;
    end else if (cnt_vld) begin
      case (state_q)
        IDLE: begin
          exp_d   = cnt_in + W'(1);
          good_d  = GW'(1);
          state_d = SYNC;
        end
        SYNC: begin
          exp_d = cnt_in + W'(1);
          if (match) begin
            good_d = good_q + GW'(1);
            if (good_q + GW'(1) == GW'(LOCK_LEN)) state_d = LOCKED;
          end else begin
            // the mismatching sample re-seeds the run and counts as its first member
            good_d = GW'(1);
          end
        end
        LOCKED: begin
          exp_d = cnt_in + W'(1);
          if (match) begin
            if (cnt_in == '0) begin
              wrap_pulse_d = 1'b1;
              wrap_cnt_d   = wrap_cnt_q + WRAP_W'(1);
            end
          end else begin
            err_pulse_d = 1'b1;
            if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + ERR_W'(1);
`ifdef COUNT_CHECKER_STICKY_EN
            state_d = FAULT;
`else
            state_d = SYNC;
            good_d  = GW'(1);
`endif
          end
        end
        default: ;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      exp_q        <= '0;
      good_q       <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_cnt_q    <= '0;
      wrap_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      good_q       <= good_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_cnt_q    <= err_cnt_d;
      wrap_cnt_q   <= wrap_cnt_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign err_cnt    = err_cnt_q;
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_cnt   = wrap_cnt_q;

endmodule
